dwt_decimate_fifo: RTL and testbench

DWT_DECIMATE_FIFO -- requirements
Module: dwt_decimate_fifo

---
 rtl/dwt_decimate_fifo.sv | 104 ++++++++++
 tb/tb_dwt_decimate_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dwt_decimate_fifo.sv
// Pairs surviving DWT downsampling are queued as {approximation, detail} entries; the head is visible one cycle after its push.
// Sticky flags record dropped pairs and lo/hi strobe disagreement. An optional cascade tap feeds approximations to the next level.
module dwt_decimate_fifo #(
  parameter int DEPTH     = 16,
  parameter bit LEVEL_FWD = 1'b1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [31:0]                lo_data,
  input  logic                       lo_parity,
  input  logic [31:0]                hi_data,
  input  logic                       hi_parity,
  input  logic                       out_ready,
  input  logic                       clear_flags,
  output logic                       out_valid,
  output logic [31:0]                out_lo,
  output logic [31:0]                out_hi,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic                       sync_err,
  output logic                       level_valid,
  output logic [31:0]                level_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_lo [DEPTH];
  logic [31:0]   mem_hi [DEPTH];
  logic [AW-1:0] rd_ptr    = '0;
  logic [AW-1:0] wr_ptr    = '0;
  logic [CW-1:0] occ       = '0;
  logic          ovf_q     = 1'b0;
  logic          sync_q    = 1'b0;
  logic          lvl_vld_q = 1'b0;
  logic [31:0]   lvl_dat_q = '0;

  logic push_req;
  logic pop;
  logic is_full;
  logic push;
  logic drop;
  logic mismatch;

  assign push_req = lo_parity & hi_parity;
  assign mismatch = lo_parity ^ hi_parity;
  assign is_full  = (occ == CW'(DEPTH));
  assign pop      = (occ != '0) & out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the pair.
  assign push     = push_req & (~is_full | pop);
  assign drop     = push_req & is_full & ~pop;

  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem_lo[wr_ptr] <= lo_data;
      mem_hi[wr_ptr] <= hi_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      ovf_q     <= 1'b0;
      sync_q    <= 1'b0;
      lvl_vld_q <= 1'b0;
      lvl_dat_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      ovf_q     <= drop | (ovf_q & ~clear_flags);
      sync_q    <= mismatch | (sync_q & ~clear_flags);
      lvl_vld_q <= push_req;
      if (push_req) lvl_dat_q <= lo_data;
    end
  end

  // Head is read straight from storage; it is masked when empty so reset shows zeros.
  assign out_valid = (occ != '0);
  assign out_lo    = out_valid ? mem_lo[rd_ptr] : '0;
  assign out_hi    = out_valid ? mem_hi[rd_ptr] : '0;
  assign count     = occ;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign sync_err  = sync_q;

  generate
    if (LEVEL_FWD) begin : g_lvl
      assign level_valid = lvl_vld_q;
      assign level_data  = lvl_dat_q;
    end else begin : g_nolvl
      assign level_valid = 1'b0;
      assign level_data  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_dwt_decimate_fifo.sv
// Bench for dwt_decimate_fifo: directed vector table, corner sequences, then random traffic against a queue model.
module tb_dwt_decimate_fifo;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] lo_data, hi_data;
  logic        lo_parity, hi_parity, out_ready, clear_flags;
  logic        out_valid, full, overflow, sync_err, level_valid;
  logic [31:0] out_lo, out_hi, level_data;
  logic [4:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  dwt_decimate_fifo #(.DEPTH(DEPTH), .LEVEL_FWD(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .lo_data(lo_data), .lo_parity(lo_parity),
    .hi_data(hi_data), .hi_parity(hi_parity),
    .out_ready(out_ready), .clear_flags(clear_flags),
    .out_valid(out_valid), .out_lo(out_lo), .out_hi(out_hi),
    .count(count), .full(full), .overflow(overflow), .sync_err(sync_err),
    .level_valid(level_valid), .level_data(level_data)
  );

  always #5 CLK = ~CLK;

  // Reference model: a queue of {lo,hi} pairs plus flag and cascade state.
  logic [63:0] mq[$];
  bit          m_ovf, m_sync, m_lv;
  logic [31:0] m_ld;

  typedef struct {
    logic [31:0] lo;
    bit          lp;
    logic [31:0] hi;
    bit          hp;
    bit          rdy;
    bit          clr;
    bit          rst;
    int          e_cnt;
    bit          e_vld;
    logic [31:0] e_lo;
    logic [31:0] e_hi;
    bit          e_ovf;
    bit          e_sync;
    bit          e_lv;
    logic [31:0] e_ld;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] lo, input bit lp, input logic [31:0] hi, input bit hp,
                       input bit rdy, input bit clr, input bit rst);
    lo_data = lo; lo_parity = lp; hi_data = hi; hi_parity = hp;
    out_ready = rdy; clear_flags = clr; RST = rst;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_step();
    bit push, pop, set_ovf;
    push = lo_parity && hi_parity;
    pop  = (mq.size() > 0) && out_ready;
    if (RST) begin
      mq.delete();
      m_ovf = 0; m_sync = 0; m_lv = 0; m_ld = '0;
      return;
    end
    set_ovf = 0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back({lo_data, hi_data});
      else set_ovf = 1;
    end
    m_ovf  = set_ovf || (m_ovf && !clear_flags);
    m_sync = (lo_parity != hi_parity) || (m_sync && !clear_flags);
    m_lv   = push;
    if (push) m_ld = lo_data;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    check({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    if (mq.size() > 0) begin
      check({tag, ".out_lo"}, out_lo, mq[0][63:32]);
      check({tag, ".out_hi"}, out_hi, mq[0][31:0]);
    end
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".sync_err"}, 32'(sync_err), 32'(m_sync));
    check({tag, ".level_valid"}, 32'(level_valid), 32'(m_lv));
    check({tag, ".level_data"}, level_data, m_ld);
  endtask

  task automatic step(input string tag, input logic [31:0] lo, input bit lp, input logic [31:0] hi,
                      input bit hp, input bit rdy, input bit clr, input bit rst);
    drive(lo, lp, hi, hp, rdy, clr, rst);
    model_step();
    tick();
    check_model(tag);
  endtask

  initial begin
    drive('0, 0, '0, 0, 0, 0, 0);
    #1;
    check("powerup.count", 32'(count), 0);
    check("powerup.out_valid", 32'(out_valid), 0);
    check("powerup.flags", {30'd0, overflow, sync_err}, 0);
    check("powerup.level_valid", 32'(level_valid), 0);

    drive('0, 0, '0, 0, 0, 0, 1);
    tick();
    tick();
    drive('0, 0, '0, 0, 0, 0, 0);
    check("reset.count", 32'(count), 0);
    check("reset.out_valid", 32'(out_valid), 0);
    check("reset.full", 32'(full), 0);
    check("reset.out_lo", out_lo, 0);
    check("reset.out_hi", out_hi, 0);
    check("reset.flags", {30'd0, overflow, sync_err}, 0);
    check("reset.level", {level_valid, level_data[30:0]}, 0);

    //           lo            lp  hi            hp rdy clr rst cnt vld lo    hi            ovf sync lv ld
    tbl[0] = '{32'h10,        1, 32'hFFFFFFF0, 1, 0,  0,  0,  1,  1, 32'h10, 32'hFFFFFFF0, 0, 0, 1, 32'h10};
    tbl[1] = '{32'h11,        0, 32'h22,       0, 0,  0,  0,  1,  1, 32'h10, 32'hFFFFFFF0, 0, 0, 0, 32'h10};
    tbl[2] = '{32'h5,         1, 32'h6,        0, 0,  0,  0,  1,  1, 32'h10, 32'hFFFFFFF0, 0, 1, 0, 32'h10};
    tbl[3] = '{32'h0,         0, 32'h0,        0, 0,  1,  0,  1,  1, 32'h10, 32'hFFFFFFF0, 0, 0, 0, 32'h10};
    tbl[4] = '{32'h0,         0, 32'h0,        1, 0,  1,  0,  1,  1, 32'h10, 32'hFFFFFFF0, 0, 1, 0, 32'h10};
    tbl[5] = '{32'h0,         0, 32'h0,        0, 0,  1,  0,  1,  1, 32'h10, 32'hFFFFFFF0, 0, 0, 0, 32'h10};
    tbl[6] = '{32'h0,         0, 32'h0,        0, 1,  0,  0,  0,  0, 32'h0,  32'h0,        0, 0, 0, 32'h10};
    tbl[7] = '{32'h7,         1, 32'h8,        1, 1,  0,  0,  1,  1, 32'h7,  32'h8,        0, 0, 1, 32'h7};
    tbl[8] = '{32'h9,         1, 32'hA,        1, 1,  0,  0,  1,  1, 32'h9,  32'hA,        0, 0, 1, 32'h9};
    tbl[9] = '{32'hC,         1, 32'hD,        1, 1,  1,  1,  0,  0, 32'h0,  32'h0,        0, 0, 0, 32'h0};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].lo, tbl[i].lp, tbl[i].hi, tbl[i].hp, tbl[i].rdy, tbl[i].clr, tbl[i].rst);
      tick();
      check($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld || tbl[i].rst) begin
        check($sformatf("vec%0d.out_lo", i), out_lo, tbl[i].e_lo);
        check($sformatf("vec%0d.out_hi", i), out_hi, tbl[i].e_hi);
      end
      check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
      check($sformatf("vec%0d.sync_err", i), 32'(sync_err), 32'(tbl[i].e_sync));
      check($sformatf("vec%0d.level_valid", i), 32'(level_valid), 32'(tbl[i].e_lv));
      check($sformatf("vec%0d.level_data", i), level_data, tbl[i].e_ld);
    end
    mq.delete();
    m_ovf = 0; m_sync = 0; m_lv = 0; m_ld = '0;

    // Fill past capacity, then drain in order.
    for (int i = 1; i <= 17; i++) step("fill", 32'(i), 1, 32'(i + 1000), 1, 0, 0, 0);
    check("fill.full", 32'(full), 1);
    check("fill.count16", 32'(count), 16);
    check("fill.overflow", 32'(overflow), 1);
    for (int i = 1; i <= 16; i++) begin
      check("drain.order", out_lo, 32'(i));
      step("drain", '0, 0, '0, 0, 1, 0, 0);
    end
    check("drain.empty", 32'(out_valid), 0);
    step("clr", '0, 0, '0, 0, 0, 1, 0);

    // Full with simultaneous push and pop keeps occupancy and flags.
    for (int i = 0; i < 16; i++) step("refill", 32'(200 + i), 1, 32'(i), 1, 0, 0, 0);
    step("fullpp", 32'hAA, 1, 32'hBB, 1, 1, 0, 0);
    check("fullpp.count", 32'(count), 16);
    check("fullpp.overflow", 32'(overflow), 0);
    for (int i = 0; i < 16 && out_valid; i++) begin
      if (count == 1) check("fullpp.last", out_lo, 32'hAA);
      step("fullpp_drain", '0, 0, '0, 0, 1, 0, 0);
    end

    // Streaming at constant occupancy across pointer wrap.
    for (int i = 0; i < 3; i++) step("wrap_pre", 32'(300 + i), 1, 32'(~(300 + i)), 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step("wrap", 32'(400 + i), 1, 32'(~(400 + i)), 1, 1, 0, 0);
      check("wrap.count3", 32'(count), 3);
    end
    for (int i = 0; i < 3; i++) step("wrap_drain", '0, 0, '0, 0, 1, 0, 0);

    // Reset mid-stream wins over push and pop.
    for (int i = 0; i < 5; i++) step("rst_pre", 32'(500 + i), 1, 32'(i), 1, 0, 0, 0);
    step("rst_pre_mm", '0, 1, '0, 0, 0, 0, 0);
    step("rst_mid", 32'h55, 1, 32'h66, 1, 1, 1, 1);
    check("rst_mid.count", 32'(count), 0);
    check("rst_mid.flags", {29'd0, overflow, sync_err, level_valid}, 0);

    // Random traffic; readiness bias changes per window so full and empty both occur.
    for (int w = 0; w < 8; w++) begin
      int rdy_pct;
      rdy_pct = (w % 2 == 0) ? 20 : 85;
      for (int c = 0; c < 100; c++) begin
        bit lp, hp;
        lp = 1'($urandom_range(0, 3) != 0);
        hp = ($urandom_range(0, 11) == 0) ? !lp : lp;
        step("rand", $urandom, lp, $urandom, hp,
             $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 19) == 0, $urandom_range(0, 249) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
